// File: rtl/axi_master_burst_write.sv
`default_nettype none
// ============================================================================
//  Module      : axi_master_burst_write
//  Description : AXI4 write-only master with INCR burst support. Accepts a
//                start request (address + AXI-encoded length), issues one AW
//                transfer, streams the beats from an upstream valid/ready
//                source onto the W channel, and reports completion together
//                with the captured B response.
//  Revision    : 1.0 - initial burst-capable release
// ----------------------------------------------------------------------------
//  Ports
//    clk, arstn                 clock (rising edge), async active-low reset
//    i_start_write              start pulse, only sampled while idle
//    i_addr, i_len              burst start address, beats minus one
//    i_wdata, i_wvalid, o_wready upstream beat stream
//    o_busy                     high whenever a burst is in flight
//    o_done                     one-cycle pulse after the B handshake
//    o_resp                     last captured B_RESP, held until next capture
//    AW_* / W_* / B_*           AXI4 write address, data and response channels
// ============================================================================
module axi_master_burst_write #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int MAX_BURST_LEN  = 16
) (
  input  logic                        clk,
  input  logic                        arstn,

  // request / upstream side
  input  logic                        i_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
  input  logic [7:0]                  i_len,
  input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
  input  logic                        i_wvalid,
  output logic                        o_wready,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [1:0]                  o_resp,

  // AXI4 write address channel
  input  logic                        AW_READY,
  output logic                        AW_VALID,
  output logic [2:0]                  AW_PROT,
  output logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  output logic [7:0]                  AW_LEN,
  output logic [2:0]                  AW_SIZE,
  output logic [1:0]                  AW_BURST,

  // AXI4 write data channel
  input  logic                        W_READY,
  output logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  output logic                        W_LAST,
  output logic                        W_VALID,

  // AXI4 write response channel
  input  logic [1:0]                  B_RESP,
  input  logic                        B_VALID,
  output logic                        B_READY
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Counter holds 0..AW_LEN+1, so one extra bit over the max beat index.
  localparam int                 c_cnt_w   = $clog2(MAX_BURST_LEN) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [7:0]         c_max_len = 8'(MAX_BURST_LEN - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_addr = 2'd1;
  localparam logic [1:0] c_st_data = 2'd2;
  localparam logic [1:0] c_st_resp = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]                r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
  logic [7:0]                r_aw_len;
  logic                      r_aw_valid;
  logic [c_cnt_w-1:0]        r_count;
  logic                      r_done;
  logic [1:0]                r_resp;

  logic                      w_in_data;
  logic                      w_w_hs;
  logic                      w_last;
  logic [7:0]                w_len_clamped;

  // Requests longer than the supported burst are truncated, not rejected.
  assign w_len_clamped = (i_len > c_max_len) ? c_max_len : i_len;

  assign w_in_data = (r_state == c_st_data);

  // Both sides widened to 9 bits so any counter width compares cleanly.
  assign w_last = (9'(r_count) == 9'(r_aw_len));

  // W is a pure pass-through of the upstream handshake while in DATA, so an
  // upstream bubble is a W bubble and W_VALID can never rise on its own.
  assign w_w_hs = w_in_data && i_wvalid && W_READY;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state    <= c_st_idle;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_valid <= 1'b0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_resp     <= 2'b00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (i_start_write) begin
            r_aw_addr  <= i_addr;
            r_aw_len   <= w_len_clamped;
            r_count    <= '0;
            r_aw_valid <= 1'b1;
            r_state    <= c_st_addr;
          end
        end
        c_st_addr: begin
          // AW_VALID is held high here, so AW_READY alone completes the transfer.
          if (AW_READY) begin
            r_aw_valid <= 1'b0;
            r_state    <= c_st_data;
          end
        end
        c_st_data: begin
          if (w_w_hs) begin
            r_count <= r_count + c_cnt_one;
            if (w_last) begin
              r_state <= c_st_resp;
            end
          end
        end
        c_st_resp: begin
          if (B_VALID) begin
            r_resp  <= B_RESP;
            r_done  <= 1'b1;
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign AW_VALID = r_aw_valid;
  assign AW_ADDR  = r_aw_addr;
  assign AW_LEN   = r_aw_len;
  assign AW_PROT  = 3'b000;
  assign AW_BURST = 2'b01;
  assign AW_SIZE  = 3'($clog2(AXI_DATA_WIDTH / 8));

  assign W_VALID  = w_in_data && i_wvalid;
  assign W_DATA   = i_wdata;
  assign W_STRB   = '1;
  assign W_LAST   = w_in_data && w_last;
  assign o_wready = w_in_data && W_READY;

  assign B_READY  = (r_state == c_st_resp);

  assign o_busy   = (r_state != c_st_idle);
  assign o_done   = r_done;
  assign o_resp   = r_resp;

endmodule
`default_nettype wire

// File: tb/tb_axi_master_burst_write.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_master_burst_write
//  Description : Directed and randomized bench for axi_master_burst_write.
//                An AXI slave model, an upstream beat source and a beat
//                scoreboard are driven cycle by cycle from one initial block.
//  Revision    : 1.0
// ============================================================================
module tb_axi_master_burst_write;

  localparam int AW   = 64;
  localparam int DW   = 32;
  localparam int MAXB = 16;

  logic          clk = 1'b0;
  logic          arstn;
  logic          i_start_write;
  logic [AW-1:0] i_addr;
  logic [7:0]    i_len;
  logic [DW-1:0] i_wdata;
  logic          i_wvalid;
  logic          o_wready;
  logic          o_busy;
  logic          o_done;
  logic [1:0]    o_resp;
  logic          AW_READY;
  logic          AW_VALID;
  logic [2:0]    AW_PROT;
  logic [AW-1:0] AW_ADDR;
  logic [7:0]    AW_LEN;
  logic [2:0]    AW_SIZE;
  logic [1:0]    AW_BURST;
  logic          W_READY;
  logic [DW-1:0] W_DATA;
  logic [DW/8-1:0] W_STRB;
  logic          W_LAST;
  logic          W_VALID;
  logic [1:0]    B_RESP;
  logic          B_VALID;
  logic          B_READY;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_master_burst_write #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .MAX_BURST_LEN  (MAXB)
  ) dut (
    .clk           (clk),
    .arstn         (arstn),
    .i_start_write (i_start_write),
    .i_addr        (i_addr),
    .i_len         (i_len),
    .i_wdata       (i_wdata),
    .i_wvalid      (i_wvalid),
    .o_wready      (o_wready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_resp        (o_resp),
    .AW_READY      (AW_READY),
    .AW_VALID      (AW_VALID),
    .AW_PROT       (AW_PROT),
    .AW_ADDR       (AW_ADDR),
    .AW_LEN        (AW_LEN),
    .AW_SIZE       (AW_SIZE),
    .AW_BURST      (AW_BURST),
    .W_READY       (W_READY),
    .W_DATA        (W_DATA),
    .W_STRB        (W_STRB),
    .W_LAST        (W_LAST),
    .W_VALID       (W_VALID),
    .B_RESP        (B_RESP),
    .B_VALID       (B_VALID),
    .B_READY       (B_READY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One burst from start request to the cycle o_done should be high.
  // Entered and left at posedge+1; the caller may issue the next start in the
  // very cycle this task returns (back-to-back).
  task automatic run_burst(input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] bresp, input int aw_stall,
                           input int wv_pct, input int wr_pct,
                           input bit seq_data, input logic [31:0] base,
                           input bit busy_start, input int abort_at,
                           output int latency);
    logic [31:0] data[$];
    int exp_len, up_idx, beats, aw_hs, stall, cyc;
    bit b_pending, b_done, do_abort;
    up_idx = 0; beats = 0; aw_hs = 0; stall = 0;
    b_pending = 0; b_done = 0; do_abort = 0;
    latency = -1;
    exp_len = (int'(len) > MAXB - 1) ? MAXB - 1 : int'(len);
    for (int i = 0; i <= exp_len; i++)
      data.push_back(seq_data ? base + 32'(i) : $urandom);

    // cycle 0: request
    chk("idle_before_start", o_busy, 0);
    i_start_write = 1'b1; i_addr = addr; i_len = len;
    AW_READY = 1'b0; W_READY = 1'b0; i_wvalid = 1'b0; B_VALID = 1'b0;
    @(posedge clk); #1; cyc = 1;
    i_start_write = 1'b0; i_addr = {$urandom, $urandom}; i_len = 8'($urandom);
    chk("aw_valid_first", AW_VALID, 1);
    chk("aw_addr", AW_ADDR, addr);
    chk("aw_len", AW_LEN, 64'(exp_len));
    chk("aw_size", AW_SIZE, 2);
    chk("aw_burst", AW_BURST, 1);
    chk("aw_prot", AW_PROT, 0);
    chk("w_strb", W_STRB, 4'hF);
    chk("busy_running", o_busy, 1);
    chk("done_low_at_start", o_done, 0);

    while (!b_done && !do_abort && cyc < 400) begin
      // slave + source drive
      AW_READY = (stall >= aw_stall);
      W_READY  = ($urandom_range(99) < wr_pct);
      i_wvalid = (up_idx <= exp_len) && ($urandom_range(99) < wv_pct);
      i_wdata  = (up_idx <= exp_len) ? data[up_idx] : $urandom;
      B_VALID  = b_pending;
      B_RESP   = b_pending ? bresp : 2'($urandom);
      i_start_write = busy_start && (beats == 1);
      #1;
      // observe
      chk("aw_addr_stable", AW_ADDR, addr);
      chk("aw_len_stable", AW_LEN, 64'(exp_len));
      if (AW_VALID) begin
        stall++;
        if (AW_READY) aw_hs++;
      end
      chk("w_valid_without_src", 64'(W_VALID && !i_wvalid), 0);
      chk("hs_coincide", 64'(i_wvalid && o_wready), 64'(W_VALID && W_READY));
      chk("b_ready_phase", B_READY, b_pending);
      if (W_VALID && W_READY) begin
        if (beats <= exp_len) chk("w_data", W_DATA, data[beats]);
        else chk("extra_beat", 64'(beats), 64'(exp_len));
        chk("w_last", W_LAST, 64'(beats == exp_len));
        if (beats == exp_len) b_pending = 1;
        beats++;
        if (beats == abort_at) do_abort = 1;
      end
      if (i_wvalid && o_wready) up_idx++;
      if (B_VALID && B_READY) b_done = 1;
      i_start_write = 1'b0;
      @(posedge clk); #1; cyc++;
    end

    if (do_abort) begin
      // upstream and slave both ready so W_VALID is high right before reset
      i_wvalid = 1'b1; W_READY = 1'b1; AW_READY = 1'b1; B_VALID = 1'b1;
      i_wdata = data[up_idx];
      #1;
      chk("pre_reset_wvalid", W_VALID, 1);
      #2; arstn = 1'b0; #1;
      chk("rst_aw_valid", AW_VALID, 0);
      chk("rst_w_valid", W_VALID, 0);
      chk("rst_wready", o_wready, 0);
      chk("rst_b_ready", B_READY, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_aw_len", AW_LEN, 0);
      i_wvalid = 1'b0; W_READY = 1'b0; AW_READY = 1'b0; B_VALID = 1'b0;
      @(posedge clk); #3; arstn = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_idle", o_busy, 0);
      return;
    end

    chk("b_handshake_seen", 64'(b_done), 1);
    B_VALID = 1'b0; W_READY = 1'b0; i_wvalid = 1'b0; AW_READY = 1'b0;
    chk("done_pulse", o_done, 1);
    chk("resp", o_resp, bresp);
    chk("busy_after_done", o_busy, 0);
    chk("beat_count", 64'(beats), 64'(exp_len + 1));
    chk("src_consumed", 64'(up_idx), 64'(exp_len + 1));
    chk("aw_hs_count", 64'(aw_hs), 1);
    chk("aw_valid_after", AW_VALID, 0);
    latency = cyc;
  endtask

  initial begin
    int lat;
    // reset with every upstream/slave input asserted
    arstn = 1'b0;
    i_start_write = 1'b0; i_addr = '0; i_len = '0; i_wdata = '0;
    i_wvalid = 1'b1; AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; B_RESP = 2'b11;
    #12;
    chk("reset_aw_valid", AW_VALID, 0);
    chk("reset_w_valid", W_VALID, 0);
    chk("reset_wready", o_wready, 0);
    chk("reset_b_ready", B_READY, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_resp", o_resp, 0);
    chk("reset_aw_addr", AW_ADDR, 0);
    chk("reset_aw_len", AW_LEN, 0);
    i_wvalid = 1'b0; AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0;
    arstn = 1'b1;
    @(posedge clk); #1;

    // single beat, all ready: o_done four cycles after start
    run_burst(64'h1000, 8'd0, 2'b00, 0, 100, 100, 1, 32'h55, 0, -1, lat);
    chk("latency_single", 64'(lat), 4);

    // burst of 4 with sequential data
    run_burst(64'h2000, 8'd3, 2'b00, 0, 100, 100, 1, 32'hA0, 0, -1, lat);
    chk("latency_burst4", 64'(lat), 7);

    // backpressure on AW, W and upstream
    run_burst(64'h3000, 8'd3, 2'b01, 3, 60, 50, 0, 32'h0, 0, -1, lat);

    // clamp to MAX_BURST_LEN and SLVERR response
    run_burst(64'h4000, 8'd40, 2'b10, 1, 80, 70, 0, 32'h0, 0, -1, lat);

    // back-to-back: issued in the o_done cycle of the previous burst
    run_burst(64'h5000, 8'd0, 2'b00, 0, 100, 100, 0, 32'h0, 0, -1, lat);
    chk("latency_back_to_back", 64'(lat), 4);

    // start request while busy is ignored
    run_burst(64'h6000, 8'd5, 2'b00, 0, 70, 70, 0, 32'h0, 1, -1, lat);

    // randomized bursts
    for (int k = 0; k < 8; k++) begin
      run_burst({$urandom, $urandom & 32'hFFFF_F000}, 8'($urandom_range(20)),
                2'($urandom), int'($urandom_range(3)),
                int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                0, 32'h0, 1'($urandom), -1, lat);
    end

    // reset mid-DATA after beat 2, then a normal burst
    run_burst(64'h7000, 8'd7, 2'b00, 0, 100, 100, 0, 32'h0, 0, 2, lat);
    chk("resp_cleared_by_reset", o_resp, 0);
    run_burst(64'h8000, 8'd2, 2'b11, 0, 100, 100, 1, 32'hC0, 0, -1, lat);
    chk("latency_after_reset", 64'(lat), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
